digital_flash_bridge: RTL



---
 rtl/digital_flash_bridge.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/digital_flash_bridge.sv
// Byte-serial bridge: splits a 1..NBYTES word access into little-endian byte
// beats on an external byte-wide memory, with wait states, ready handshake,
// a beat timeout and a single-cycle completion pulse.
module digital_flash_bridge #(
   parameter int XLEN        = 32,
   parameter int ADDR_W      = 32,
   parameter int WAIT_CYCLES = 1,
   parameter int TIMEOUT     = 64,
   localparam int NBYTES     = XLEN / 8,
   localparam int SW         = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
   input  logic              flashclk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] flash_io_addr,
   input  logic              flash_io_read,
   input  logic              flash_io_write,
   input  logic [SW-1:0]     io_byte_size,
   input  logic [XLEN-1:0]   flash_io_wdata,
   output logic [XLEN-1:0]   flash_io_rdata,
   output logic              flash_io_ready,
   output logic              flash_io_error,
   output logic [ADDR_W-1:0] digital_flash_addr,
   output logic              digital_flash_read_en,
   output logic              digital_flash_write_en,
   output logic [7:0]        digital_flash_wdata,
   input  logic [7:0]        digital_flash_data,
   input  logic              digital_flash_ready
);

   localparam int WW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, BEAT, DONE, REARM} state_t;

   state_t            state, state_nxt;
   logic              op_wr;
   logic [ADDR_W-1:0] base;
   logic [XLEN-1:0]   wd_l;
   logic [SW-1:0]     last_k, k;
   logic [WW-1:0]     wcnt;
   logic [TW-1:0]     tcnt;
   logic              err;
   logic [XLEN-1:0]   rdata;

   logic              one_req, both_req;
   logic              waited, beat_ok, stall, tmo;

   assign one_req  = flash_io_read ^ flash_io_write;
   assign both_req = flash_io_read & flash_io_write;
   assign waited   = (int'(wcnt) == WAIT_CYCLES);
   assign beat_ok  = waited & digital_flash_ready;
   assign stall    = waited & ~digital_flash_ready;
   // A zero TIMEOUT means a beat may stall forever.
   assign tmo      = stall && (TIMEOUT != 0) && (int'(tcnt) == TIMEOUT - 1);

   // State register; reset aborts any access without a completion pulse.
   always_ff @(posedge flashclk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (one_req) state_nxt = BEAT;
                  else if (both_req) state_nxt = DONE;
         BEAT:    if ((beat_ok && k == last_k) || tmo) state_nxt = DONE;
         DONE:    state_nxt = REARM;
         REARM:   if (!flash_io_read && !flash_io_write) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch, beat/wait/timeout counters and read-data assembly.
   always_ff @(posedge flashclk or negedge rst) begin
      if (!rst) begin
         op_wr  <= 1'b0;
         base   <= '0;
         wd_l   <= '0;
         last_k <= '0;
         k      <= '0;
         wcnt   <= '0;
         tcnt   <= '0;
         err    <= 1'b0;
         rdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               k    <= '0;
               wcnt <= '0;
               tcnt <= '0;
               err  <= both_req;
               if (one_req) begin
                  op_wr  <= flash_io_write;
                  base   <= flash_io_addr;
                  wd_l   <= flash_io_wdata;
                  last_k <= (io_byte_size == '0) ? SW'(NBYTES - 1) : io_byte_size - 1'b1;
               end
               // Read data starts from zero on every accepted read (and on an
               // illegal request) so partial or failed reads show zero bytes.
               if (flash_io_read) rdata <= '0;
            end
            BEAT: begin
               if (beat_ok) begin
                  if (!op_wr) rdata[8*k +: 8] <= digital_flash_data;
                  k    <= k + 1'b1;
                  wcnt <= '0;
                  tcnt <= '0;
               end else if (!waited) begin
                  wcnt <= wcnt + 1'b1;
               end else if (tmo) begin
                  err <= 1'b1;
               end else if (TIMEOUT != 0) begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // External pins are only active during a beat; completion is a DONE pulse.
   always_comb begin
      digital_flash_addr     = '0;
      digital_flash_read_en  = 1'b0;
      digital_flash_write_en = 1'b0;
      digital_flash_wdata    = '0;
      if (state == BEAT) begin
         digital_flash_addr     = base + ADDR_W'(k);
         digital_flash_read_en  = ~op_wr;
         digital_flash_write_en = op_wr;
         if (op_wr) digital_flash_wdata = wd_l[8*k +: 8];
      end
   end

   assign flash_io_ready = (state == DONE);
   assign flash_io_error = (state == DONE) & err;
   assign flash_io_rdata = rdata;

endmodule
